// File: rtl/input_debouncer.sv
// Synchronises and debounces eight raw switch inputs, producing debounced levels,
// one-cycle rise/fall pulses and a sticky rise-event register cleared by ack.
module input_debouncer #(
    parameter logic [15:0] DEBOUNCE_DIV = 16'd1000,
    parameter logic [7:0]  STABLE_TICKS = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw_raw,
    input  logic       ack,
    output logic [7:0] sw_out,
    output logic [7:0] rise,
    output logic [7:0] fall,
    output logic [7:0] evt,
    output logic       any_evt
);

    logic [7:0]       sync1_q;
    logic [7:0]       sync2_q;
    logic [15:0]      pre_q;
    logic [15:0]      pre_d;
    logic             tick_s;
    logic [7:0][7:0]  cnt_q;
    logic [7:0][7:0]  cnt_d;
    logic [7:0]       sw_out_q;
    logic [7:0]       sw_out_d;
    logic [7:0]       rise_q;
    logic [7:0]       rise_d;
    logic [7:0]       fall_q;
    logic [7:0]       fall_d;
    logic [7:0]       evt_q;
    logic [7:0]       evt_d;
    logic             any_evt_q;
    logic             any_evt_d;

    // Next-state logic: prescaler, per-bit debounce counters, edge pulses, sticky events
    always_comb begin
        tick_s = (pre_q == (DEBOUNCE_DIV - 16'd1));
        if (tick_s) begin
            pre_d = 16'd0;
        end else begin
            pre_d = pre_q + 16'd1;
        end

        cnt_d    = cnt_q;
        sw_out_d = sw_out_q;
        for (int i = 0; i < 8; i++) begin
            // Any agreement, tick or not, abandons the pending change so a bounce restarts the count
            if (sync2_q[i] == sw_out_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (tick_s) begin
                if (cnt_q[i] == (STABLE_TICKS - 8'd1)) begin
                    sw_out_d[i] = sync2_q[i];
                    cnt_d[i]    = 8'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end

        rise_d = sw_out_d & ~sw_out_q;
        fall_d = ~sw_out_d & sw_out_q;

        // A rise pulse coinciding with ack survives the clear
        if (ack) begin
            evt_d = 8'h00 | rise_q;
        end else begin
            evt_d = evt_q | rise_q;
        end
        any_evt_d = |evt_d;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 8'h00;
            sync2_q   <= 8'h00;
            pre_q     <= 16'd0;
            cnt_q     <= '0;
            sw_out_q  <= 8'h00;
            rise_q    <= 8'h00;
            fall_q    <= 8'h00;
            evt_q     <= 8'h00;
            any_evt_q <= 1'b0;
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            sw_out_q  <= sw_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            evt_q     <= evt_d;
            any_evt_q <= any_evt_d;
        end
    end

    assign sw_out  = sw_out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign evt     = evt_q;
    assign any_evt = any_evt_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer: a DIV=4/STABLE=3 instance and a DIV=1/STABLE=1 instance.
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_a, sw_b;
    logic       ack_a, ack_b;
    logic [7:0] sw_out_a, rise_a, fall_a, evt_a;
    logic [7:0] sw_out_b, rise_b, fall_b, evt_b;
    logic       any_a, any_b;
    int         errors = 0;
    int         checks = 0;
    int         n;
    logic       bad;

    input_debouncer #(.DEBOUNCE_DIV(16'd4), .STABLE_TICKS(8'd3)) dut_a (
        .clk(clk), .rst(rst), .sw_raw(sw_a), .ack(ack_a),
        .sw_out(sw_out_a), .rise(rise_a), .fall(fall_a), .evt(evt_a), .any_evt(any_a)
    );

    input_debouncer #(.DEBOUNCE_DIV(16'd1), .STABLE_TICKS(8'd1)) dut_b (
        .clk(clk), .rst(rst), .sw_raw(sw_b), .ack(ack_b),
        .sw_out(sw_out_b), .rise(rise_b), .fall(fall_b), .evt(evt_b), .any_evt(any_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(input logic [7:0] mask, input logic [7:0] val, input int limit, output int cnt);
        cnt = 0;
        while (((sw_out_a & mask) != (val & mask)) && (cnt < limit)) begin
            step();
            cnt++;
        end
    endtask

    task automatic step_mon();
        step();
        if (sw_out_a[0] || rise_a[0] || fall_a[0]) bad = 1'b1;
    endtask

    initial begin
        rst = 1'b1; sw_a = 8'hFF; sw_b = 8'h00; ack_a = 1'b0; ack_b = 1'b0; bad = 1'b0;
        repeat (3) step();
        check("rst_sw_out", {8'h00, sw_out_a}, 16'h0000);
        check("rst_rise",   {8'h00, rise_a},   16'h0000);
        check("rst_fall",   {8'h00, fall_a},   16'h0000);
        check("rst_evt",    {8'h00, evt_a},    16'h0000);
        check("rst_any",    {15'd0, any_a},    16'h0000);
        check("rst_b_out",  {8'h00, sw_out_b}, 16'h0000);

        // Held high through reset: prescaler phase is known, so latency is exactly 12 edges
        rst = 1'b0;
        wait_a(8'hFF, 8'hFF, 20, n);
        check("t1_latency", n[15:0], 16'd12);
        check("t1_rise",    {8'h00, rise_a}, 16'h00FF);
        check("t1_evt_lag", {8'h00, evt_a},  16'h0000);
        step();
        check("t1_rise_off", {8'h00, rise_a}, 16'h0000);
        check("t1_evt",      {8'h00, evt_a},  16'h00FF);
        check("t1_any",      {15'd0, any_a},  16'h0001);

        sw_a = 8'h00; rst = 1'b1;
        #1;
        check("rst_async_out", {8'h00, sw_out_a}, 16'h0000);
        check("rst_async_evt", {8'h00, evt_a},    16'h0000);
        step(); rst = 1'b0;
        repeat (20) step();
        check("idle_out",  {8'h00, sw_out_a}, 16'h0000);
        check("idle_fall", {8'h00, fall_a},   16'h0000);

        // Reset while bit7 is pending, then held high through release
        sw_a = 8'h80;
        repeat (8) step();
        rst = 1'b1; step();
        check("midpend_rise", {8'h00, rise_a}, 16'h0000);
        rst = 1'b0;
        wait_a(8'h80, 8'h80, 20, n);
        check("midpend_lat",  n[15:0], 16'd12);
        check("midpend_rise2", {8'h00, rise_a}, 16'h0080);
        sw_a = 8'h00;
        wait_a(8'h80, 8'h00, 30, n);
        ack_a = 1'b1; step(); ack_a = 1'b0; step();
        check("midpend_clr", {8'h00, evt_a}, 16'h0000);

        // Clean press on bit 3 at an arbitrary prescaler phase
        repeat (3) step();
        sw_a = 8'h08;
        wait_a(8'h08, 8'h08, 30, n);
        check("t2_lat_range", {15'd0, (n >= 11 && n <= 14)}, 16'h0001);
        check("t2_out",  {8'h00, sw_out_a}, 16'h0008);
        check("t2_rise", {8'h00, rise_a},   16'h0008);
        check("t2_fall", {8'h00, fall_a},   16'h0000);
        step();
        check("t2_rise_off", {8'h00, rise_a}, 16'h0000);
        check("t2_evt",      {8'h00, evt_a},  16'h0008);
        check("t2_any",      {15'd0, any_a},  16'h0001);

        // Bounce on bit 0 never holds long enough
        repeat (5) begin
            sw_a = 8'h09;
            repeat (6) step_mon();
            sw_a = 8'h08;
            repeat (3) step_mon();
        end
        repeat (10) step_mon();
        check("t3_no_activity", {15'd0, bad}, 16'h0000);
        check("t3_out", {8'h00, sw_out_a}, 16'h0008);
        check("t3_evt", {8'h00, evt_a},    16'h0008);

        // Ack clears, then release gives a fall that does not touch evt
        ack_a = 1'b1; step(); ack_a = 1'b0;
        check("t4_evt_clr", {8'h00, evt_a}, 16'h0000);
        check("t4_any_clr", {15'd0, any_a}, 16'h0000);
        sw_a = 8'h00;
        wait_a(8'h08, 8'h00, 30, n);
        check("t4_lat_range", {15'd0, (n >= 11 && n <= 14)}, 16'h0001);
        check("t4_fall", {8'h00, fall_a}, 16'h0008);
        check("t4_rise", {8'h00, rise_a}, 16'h0000);
        step();
        check("t4_fall_off", {8'h00, fall_a}, 16'h0000);
        check("t4_evt",      {8'h00, evt_a},  16'h0000);

        // Ack on the exact cycle rise[5] fires
        sw_a = 8'h01;
        wait_a(8'h01, 8'h01, 30, n);
        step();
        check("t5_evt_pre", {8'h00, evt_a}, 16'h0001);
        sw_a = 8'h21;
        n = 0;
        while (!rise_a[5] && n < 30) begin
            step();
            n++;
        end
        check("t5_rise5",   {8'h00, rise_a}, 16'h0020);
        check("t5_evt_now", {8'h00, evt_a},  16'h0001);
        ack_a = 1'b1; step(); ack_a = 1'b0;
        check("t5_evt", {8'h00, evt_a}, 16'h0020);
        check("t5_any", {15'd0, any_a}, 16'h0001);

        // DIV=1, STABLE=1: step appears exactly 3 edges later
        sw_b = 8'hA5;
        step();
        check("t6_e1", {8'h00, sw_out_b}, 16'h0000);
        step();
        check("t6_e2", {8'h00, sw_out_b}, 16'h0000);
        step();
        check("t6_e3",   {8'h00, sw_out_b}, 16'h00A5);
        check("t6_rise", {8'h00, rise_b},   16'h00A5);
        step();
        check("t6_rise_off", {8'h00, rise_b}, 16'h0000);
        check("t6_evt",      {8'h00, evt_b},  16'h00A5);
        check("t6_any",      {15'd0, any_b},  16'h0001);

        // One-cycle glitch on bit 1 passes straight through
        sw_b = 8'hA7; step();
        sw_b = 8'hA5; step(); step();
        check("t6_glitch_rise", {8'h00, rise_b}, 16'h0002);
        step();
        check("t6_glitch_fall", {8'h00, fall_b},   16'h0002);
        check("t6_glitch_out",  {8'h00, sw_out_b}, 16'h00A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditioning stage directly upstream of the computer's input register; it feeds that register from the `ui_in` switch pins.
- It synchronises and debounces the 8 raw switch inputs.
- It produces one-cycle rise/fall pulses and a sticky per-bit event register that the CPU clears with an acknowledge.
- All logic runs in the single core clock domain.

Parameters:
- DEBOUNCE_DIV, 16'd1000, prescaler period in clk cycles between sample ticks (legal range 1..65535; 1 = tick every cycle)
- STABLE_TICKS, 8'd4, consecutive mismatching ticks required before the debounced value changes (legal range 1..255)

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- sw_raw  input  8  raw switch pins (ui_in), asynchronous to clk
- ack  input  1  clears the sticky event register (driven by the io output strobe)
- sw_out  output  8  debounced switch value
- rise  output  8  one-cycle pulse per bit on debounced 0->1
- fall  output  8  one-cycle pulse per bit on debounced 1->0
- evt  output  8  sticky per-bit rise flags
- any_evt  output  1  OR-reduction of evt, registered

Behaviour:
- Reset (async, rst=1): sync stages, prescaler, all per-bit counters, sw_out, rise, fall, evt and any_evt = 0. Reset applies immediately, including mid-count; after release, counting restarts from 0.
- Synchroniser: 2-flop chain per bit. sync[i] is sw_raw[i] delayed 2 clk edges. No logic is driven from sw_raw directly.
- Prescaler: counter 0..DEBOUNCE_DIV-1.
  - tick=1 in the cycle where counter == DEBOUNCE_DIV-1; the counter wraps to 0 on the next edge.
  - With DEBOUNCE_DIV=1, tick is constantly 1.
  - Counter width is 16 bits.
- Per-bit state machine (independent ×8), two states:
  - STABLE: cnt=0.
  - PENDING: sync[i] != sw_out[i].
- PENDING transitions:
  - Any cycle (tick or not) with sync[i] == sw_out[i]: cnt <= 0, back to STABLE. A bounce therefore restarts the count.
  - On tick with mismatch: if cnt == STABLE_TICKS-1, then sw_out[i] <= sync[i] and cnt <= 0; otherwise cnt <= cnt+1.
  - cnt width is 8 bits; it never exceeds STABLE_TICKS-1 and never wraps.
- Pulses: rise[i]/fall[i] are registered and high for exactly the one cycle in which sw_out[i] first shows its new value. Both are 0 otherwise. rise and fall are never both high on the same bit.
- Latency from sw_raw change (held stable) to sw_out change:
  - Minimum 2 + (STABLE_TICKS-1)·DEBOUNCE_DIV + 1 cycles.
  - Maximum 2 + STABLE_TICKS·DEBOUNCE_DIV cycles, depending on prescaler phase.
- Sticky events: evt <= (ack ? 8'h00 : evt) | rise. When ack and rise coincide on the same cycle, the new rise wins: the bit ends set. fall never affects evt.
- any_evt: registered |evt_next, so it matches evt on the same cycle.
- Multiple bits changing simultaneously debounce independently. Identical timing yields simultaneous pulses.
- Reset mid-PENDING: no pulse is emitted; sw_out returns to 0. If a switch is held high through reset, it produces a rise after the normal latency once rst is released.

Test Plan:
- Reset/idle (DIV=4, STABLE=3): rst=1 with sw_raw=8'hFF -> all outputs 0 while rst is high. Release rst -> sw_out=8'hFF within 2+12=14 cycles; rise=8'hFF for exactly 1 cycle; evt=8'hFF; any_evt=1.
- Clean press (DIV=4, STABLE=3): sw_raw[3] 0->1 and held -> sw_out[3]=1 between cycle 11 and 14 after the change. rise=8'h08 for one cycle; evt=8'h08; other bits unchanged.
- Bounce rejection: sw_raw[0] toggles 1 for 6 cycles, 0 for 3 cycles, repeated 5 times, then back to 0 -> sw_out[0] stays 0; no rise/fall pulses; evt unchanged.
- Release and ack: from sw_out=8'h08/evt=8'h08, pulse ack 1 cycle -> evt=0, any_evt=0. Then drop sw_raw[3] -> fall=8'h08 for one cycle; evt stays 0.
- Ack/rise collision: assert ack on the exact cycle rise[5] fires, with evt=8'h01 beforehand -> evt=8'h20 (bit0 cleared, bit5 set); any_evt=1.
- DIV=1, STABLE=1 boundary: sw_raw=8'hA5 step -> sw_out=8'hA5 exactly 3 cycles later; rise=8'hA5 for one cycle. A 1-cycle glitch that is visible on sync also produces a pulse.
